ras_commit_tracker: RTL and testbench

- Commit-side companion of the return address stack in the IFU.
- Records every fetch-time RAS push/pop and its predicted target in a FIFO. Pops the oldest entry when the ROB commits the matching link/return.
- Drives the RAS committed-copy update signals and detects return-target mispredictions. On a misprediction it issues a one-cycle RAS recover pulse and a fetch redirect.

---
 rtl/ras_commit_tracker.sv | 135 +++++++++++++
 tb/tb_ras_commit_tracker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ras_commit_tracker.sv
// ras_commit_tracker: commit-side shadow of the IFU return address stack.
// Records fetch-time RAS push/pop events (with predicted return target) in a
// FIFO and retires them in order as the ROB commits calls/returns.
//   clk, rst            : clock, async active-high reset
//   pause, enq_*        : fetch-side RAS event (enqueue)
//   cmt_*               : ROB commit of a call/return
//   flush_in            : external flush, forces a RAS recover
//   commit_valid, committed_* : registered commit info for the RAS committed copy
//   recover             : one-cycle RAS recover pulse (mispredict/desync/flush)
//   redirect_valid/target : one-cycle fetch redirect on a return mispredict
//   full, empty, count  : queue occupancy
//   desync_err          : sticky commit/queue mismatch
//   mispredict_cnt      : saturating return-mispredict counter
module ras_commit_tracker #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             enq_valid,
  input  logic             enq_isLink,
  input  logic             enq_isReturn,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_pred_target,
  input  logic             cmt_valid,
  input  logic             cmt_isLink,
  input  logic             cmt_isReturn,
  input  logic [31:0]      cmt_pc,
  input  logic [31:0]      cmt_actual_target,
  input  logic             flush_in,
  output logic             commit_valid,
  output logic             committed_isLink,
  output logic             committed_isReturn,
  output logic [31:0]      committed_pc,
  output logic             recover,
  output logic             redirect_valid,
  output logic [31:0]      redirect_target,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             desync_err,
  output logic [31:0]      mispredict_cnt
);

  // Entry storage; contents are don't-care outside [head, tail), so no reset.
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] pred_mem [DEPTH];
  logic        link_mem [DEPTH];
  logic        ret_mem  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;

  logic enq;
  logic cmt_ev;
  logic head_match;
  logic pop;
  logic mispred;
  logic desync;
  logic recover_nxt;

  assign full  = (cnt == (PTR_W+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  always_comb begin
    enq         = enq_valid & (enq_isLink | enq_isReturn) & ~pause & ~full & ~recover;
    cmt_ev      = cmt_valid & (cmt_isLink | cmt_isReturn);
    head_match  = ~empty & (pc_mem[head] == cmt_pc);
    pop         = cmt_ev & head_match;
    mispred     = pop & ret_mem[head] & (pred_mem[head] != cmt_actual_target);
    desync      = cmt_ev & ~head_match;
    // The commit is evaluated before the flush: it is older, so its outputs
    // still register even though the queue is cleared at the same edge.
    recover_nxt = mispred | desync | flush_in;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]   <= enq_pc;
      pred_mem[tail] <= enq_pred_target;
      link_mem[tail] <= enq_isLink;
      ret_mem[tail]  <= enq_isReturn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (recover_nxt) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      case ({enq, pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid       <= 1'b0;
      committed_isLink   <= 1'b0;
      committed_isReturn <= 1'b0;
      committed_pc       <= '0;
      recover            <= 1'b0;
      redirect_valid     <= 1'b0;
      redirect_target    <= '0;
      desync_err         <= 1'b0;
      mispredict_cnt     <= '0;
    end else begin
      commit_valid       <= cmt_ev;
      committed_isLink   <= cmt_ev & cmt_isLink;
      committed_isReturn <= cmt_ev & cmt_isReturn;
      committed_pc       <= cmt_ev ? cmt_pc : '0;
      recover            <= recover_nxt;
      redirect_valid     <= mispred;
      redirect_target    <= mispred ? cmt_actual_target : '0;
      if (desync)
        desync_err <= 1'b1;
      if (mispred && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ras_commit_tracker.sv
module tb_ras_commit_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause, enq_valid, enq_isLink, enq_isReturn;
  logic [31:0] enq_pc, enq_pred_target;
  logic        cmt_valid, cmt_isLink, cmt_isReturn;
  logic [31:0] cmt_pc, cmt_actual_target;
  logic        flush_in;
  logic        commit_valid, committed_isLink, committed_isReturn;
  logic [31:0] committed_pc;
  logic        recover, redirect_valid;
  logic [31:0] redirect_target;
  logic        full, empty;
  logic [4:0]  count;
  logic        desync_err;
  logic [31:0] mispredict_cnt;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  ras_commit_tracker #(.DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .enq_valid(enq_valid), .enq_isLink(enq_isLink), .enq_isReturn(enq_isReturn),
    .enq_pc(enq_pc), .enq_pred_target(enq_pred_target),
    .cmt_valid(cmt_valid), .cmt_isLink(cmt_isLink), .cmt_isReturn(cmt_isReturn),
    .cmt_pc(cmt_pc), .cmt_actual_target(cmt_actual_target),
    .flush_in(flush_in),
    .commit_valid(commit_valid), .committed_isLink(committed_isLink),
    .committed_isReturn(committed_isReturn), .committed_pc(committed_pc),
    .recover(recover), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .full(full), .empty(empty), .count(count),
    .desync_err(desync_err), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    pause = 0; enq_valid = 0; enq_isLink = 0; enq_isReturn = 0;
    enq_pc = '0; enq_pred_target = '0;
    cmt_valid = 0; cmt_isLink = 0; cmt_isReturn = 0;
    cmt_pc = '0; cmt_actual_target = '0; flush_in = 0;
  endtask

  task automatic drive_enq(input logic lnk, input logic ret, input logic [31:0] pc,
                           input logic [31:0] pred);
    enq_valid = 1; enq_isLink = lnk; enq_isReturn = ret; enq_pc = pc; enq_pred_target = pred;
  endtask

  task automatic drive_cmt(input logic lnk, input logic ret, input logic [31:0] pc,
                           input logic [31:0] act);
    cmt_valid = 1; cmt_isLink = lnk; cmt_isReturn = ret; cmt_pc = pc; cmt_actual_target = act;
  endtask

  // Advance one edge, land 1 time unit after it, and release all inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_recover", 32'(recover), 32'd0);
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_desync", 32'(desync_err), 32'd0);
    chk("rst_mcnt", mispredict_cnt, 32'd0);
    @(negedge clk);
    rst = 0;
    tick();

    // Push/pop match
    drive_enq(1, 0, 32'h100, 32'h0); tick();
    drive_enq(0, 1, 32'h200, 32'h108); tick();
    chk("pp_count2", 32'(count), 32'd2);
    drive_cmt(1, 0, 32'h100, 32'h500); tick();
    chk("pp_cv1", 32'(commit_valid), 32'd1);
    chk("pp_pc1", committed_pc, 32'h100);
    chk("pp_link1", 32'(committed_isLink), 32'd1);
    chk("pp_rec1", 32'(recover), 32'd0);
    chk("pp_count1", 32'(count), 32'd1);
    drive_cmt(0, 1, 32'h200, 32'h108); tick();
    chk("pp_cv2", 32'(commit_valid), 32'd1);
    chk("pp_pc2", committed_pc, 32'h200);
    chk("pp_ret2", 32'(committed_isReturn), 32'd1);
    chk("pp_rec2", 32'(recover), 32'd0);
    chk("pp_redir2", 32'(redirect_valid), 32'd0);
    chk("pp_count0", 32'(count), 32'd0);
    chk("pp_empty", 32'(empty), 32'd1);
    tick();
    chk("pp_cv_idle", 32'(commit_valid), 32'd0);

    // Return mispredict
    drive_enq(0, 1, 32'h300, 32'h10C); tick();
    chk("mp_count1", 32'(count), 32'd1);
    drive_cmt(0, 1, 32'h300, 32'h208); tick();
    chk("mp_recover", 32'(recover), 32'd1);
    chk("mp_redir", 32'(redirect_valid), 32'd1);
    chk("mp_target", redirect_target, 32'h208);
    chk("mp_count0", 32'(count), 32'd0);
    chk("mp_mcnt", mispredict_cnt, 32'd1);
    chk("mp_no_desync", 32'(desync_err), 32'd0);
    drive_enq(1, 0, 32'h500, 32'h0); tick();
    chk("mp_enq_dropped", 32'(count), 32'd0);
    chk("mp_rec_pulse", 32'(recover), 32'd0);
    chk("mp_redir_pulse", 32'(redirect_valid), 32'd0);

    // Full / wrap
    for (int i = 0; i < 16; i++) begin
      drive_enq(1, 0, 32'h1000 + 32'(i) * 4, 32'h0);
      exp_q.push_back(32'h1000 + 32'(i) * 4);
      tick();
    end
    chk("fw_count16", 32'(count), 32'd16);
    chk("fw_full", 32'(full), 32'd1);
    exp_pc = exp_q.pop_front();
    drive_enq(1, 0, 32'h2000, 32'h0);
    drive_cmt(1, 0, exp_pc, 32'h0);
    tick();
    chk("fw_count15", 32'(count), 32'd15);
    chk("fw_notfull", 32'(full), 32'd0);
    chk("fw_pc_first", committed_pc, 32'h1000);
    chk("fw_rec", 32'(recover), 32'd0);
    for (int k = 0; k < 20; k++) begin
      exp_pc = exp_q.pop_front();
      drive_enq(1, 0, 32'h3000 + 32'(k) * 4, 32'h0);
      exp_q.push_back(32'h3000 + 32'(k) * 4);
      drive_cmt(1, 0, exp_pc, 32'h0);
      tick();
      chk($sformatf("fw_pair%0d_pc", k), committed_pc, exp_pc);
      chk($sformatf("fw_pair%0d_count", k), 32'(count), 32'd15);
      chk($sformatf("fw_pair%0d_rec", k), 32'(recover), 32'd0);
    end

    // flush_in alone empties the queue
    flush_in = 1; tick();
    chk("fl_recover", 32'(recover), 32'd1);
    chk("fl_redir", 32'(redirect_valid), 32'd0);
    chk("fl_count", 32'(count), 32'd0);
    tick();

    // Desync on empty queue
    drive_cmt(0, 1, 32'h400, 32'h0); tick();
    chk("ds_recover", 32'(recover), 32'd1);
    chk("ds_err", 32'(desync_err), 32'd1);
    chk("ds_redir", 32'(redirect_valid), 32'd0);
    chk("ds_cv", 32'(commit_valid), 32'd1);
    chk("ds_pc", committed_pc, 32'h400);
    chk("ds_mcnt", mispredict_cnt, 32'd1);
    tick();
    chk("ds_sticky", 32'(desync_err), 32'd1);
    chk("ds_rec_pulse", 32'(recover), 32'd0);

    // flush_in with a matching commit in the same cycle
    drive_enq(1, 0, 32'h600, 32'h0); tick();
    drive_enq(1, 0, 32'h604, 32'h0); tick();
    drive_enq(1, 0, 32'h608, 32'h0); tick();
    chk("fc_count3", 32'(count), 32'd3);
    flush_in = 1;
    drive_cmt(1, 0, 32'h600, 32'h0);
    tick();
    chk("fc_cv", 32'(commit_valid), 32'd1);
    chk("fc_pc", committed_pc, 32'h600);
    chk("fc_recover", 32'(recover), 32'd1);
    chk("fc_redir", 32'(redirect_valid), 32'd0);
    chk("fc_count", 32'(count), 32'd0);
    tick();

    // Async reset mid-stream
    for (int i = 0; i < 5; i++) begin
      drive_enq(1, 0, 32'h700 + 32'(i) * 4, 32'h0);
      tick();
    end
    drive_enq(1, 0, 32'h714, 32'h0);
    drive_cmt(1, 0, 32'h700, 32'h0);
    tick();
    chk("ar_count5", 32'(count), 32'd5);
    chk("ar_cv_before", 32'(commit_valid), 32'd1);
    #2;
    rst = 1;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_cv", 32'(commit_valid), 32'd0);
    chk("ar_recover", 32'(recover), 32'd0);
    chk("ar_redir", 32'(redirect_valid), 32'd0);
    chk("ar_desync", 32'(desync_err), 32'd0);
    chk("ar_mcnt", mispredict_cnt, 32'd0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("ar_post_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
